// File: rtl/serial_adder_32bit.sv
// rtl/serial_adder_32bit.sv - bit-serial a + b + cin, one bit per clock
// Start/busy/done handshake; the result register only changes when an operation completes.
module serial_adder_32bit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  // Holds the WIDTH-1 bits already produced; the final bit joins them on the last edge.
  logic [WIDTH-2:0] sum_sh_q, sum_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic s_bit;
  logic c_next;

  assign s_bit  = a_sh_q[0] ^ b_sh_q[0] ^ c_q;
  assign c_next = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & c_q) | (b_sh_q[0] & c_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      c_q      <= 1'b0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      c_q      <= c_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    c_d      = c_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          a_sh_d   = a;
          b_sh_d   = b;
          c_d      = cin;
          cnt_d    = '0;
          sum_sh_d = '0;
        end
      end
      RUN: begin
        c_d      = c_next;
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        sum_sh_d = {s_bit, sum_sh_q[WIDTH-2:1]};
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          cnt_d   = '0;
          sum_d   = {s_bit, sum_sh_q};
          cout_d  = c_next;
          ovf_d   = c_q ^ c_next;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign sum       = sum_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_adder_32bit.sv
// tb/tb_serial_adder_32bit.sv - self-checking bench for serial_adder_32bit
// Random and directed operations checked against a plain-arithmetic reference model.
module tb_serial_adder_32bit;

  logic        clk = 1'b0;
  logic        reset_r = 1'b1;
  logic        start_r = 1'b0;
  logic [31:0] a_r = '0;
  logic [31:0] b_r = '0;
  logic        cin_r = 1'b0;
  logic        busy, done, carry_out, overflow;
  logic [31:0] sum;

  int checks = 0;
  int failures = 0;

  logic [31:0] last_sum = '0;
  logic        last_co  = 1'b0;
  logic        last_ov  = 1'b0;

  always #5 clk = ~clk;

  serial_adder_32bit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset_r), .start(start_r), .a(a_r), .b(b_r), .cin(cin_r),
    .busy(busy), .done(done), .sum(sum), .carry_out(carry_out), .overflow(overflow)
  );

  // {overflow, carry_out, sum} from integer addition and the sign rule
  function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y, input logic c);
    logic [32:0] full;
    logic        ov;
    full = {1'b0, x} + {1'b0, y} + {32'd0, c};
    ov   = (x[31] == y[31]) && (full[31] != x[31]);
    return {ov, full[32], full[31:0]};
  endfunction

  // Launches one op, scrambles inputs after acceptance, optionally pulses start at cycle inject_at.
  task automatic do_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic tc,
                       input int inject_at, output int done_at, output int ndone,
                       output int nbusy, output bit early);
    @(negedge clk);
    a_r = ta; b_r = tb_v; cin_r = tc; start_r = 1'b1;
    @(posedge clk); #1;
    start_r = 1'b0;
    a_r = $urandom; b_r = $urandom; cin_r = 1'($urandom_range(0, 1));
    done_at = -1; ndone = 0; nbusy = 0; early = 1'b0;
    for (int cyc = 0; cyc < 36; cyc++) begin
      if (cyc > 0) begin
        @(posedge clk); #1;
      end
      start_r = 1'b0;
      if (busy) nbusy++;
      if (done) begin
        ndone++;
        if (done_at < 0) done_at = cyc;
      end
      if (cyc < 32 && (sum !== last_sum || carry_out !== last_co || overflow !== last_ov))
        early = 1'b1;
      if (cyc == inject_at) begin
        start_r = 1'b1; a_r = $urandom; b_r = $urandom; cin_r = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, carry_out, overflow} !== 4'b0 || sum !== 32'd0) begin
      failures++;
      $display("FAIL reset_state: busy=%b done=%b sum=%h co=%b ov=%b required all 0",
               busy, done, sum, carry_out, overflow);
    end
    start_r = 1'b1; a_r = 32'hdead_beef; b_r = 32'h1; cin_r = 1'b1;
    @(posedge clk); #1;
    reset_r = 1'b0; start_r = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_beats_start: busy=%b required 0", busy);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle_after: busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  task automatic test_directed;
    logic [31:0] ta [6] = '{32'h5, 32'hffff_ffff, 32'h7fff_ffff, 32'h8000_0000, 32'h1234_5678, 32'hffff_ffff};
    logic [31:0] tb_v [6] = '{32'h3, 32'h1, 32'h1, 32'h8000_0000, 32'hffff_eeee, 32'hffff_ffff};
    logic        tc [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] es [6] = '{32'h8, 32'h0, 32'h8000_0000, 32'h0, 32'h1234_4567, 32'hffff_ffff};
    logic        eco [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic        eov [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    int dat, nd, nb;
    bit early;
    for (int i = 0; i < 6; i++) begin
      do_op(ta[i], tb_v[i], tc[i], -1, dat, nd, nb, early);
      checks++;
      if (dat !== 32 || nd !== 1 || nb !== 32) begin
        failures++;
        $display("FAIL directed_timing[%0d]: done_at=%0d ndone=%0d busy=%0d required 32 1 32", i, dat, nd, nb);
      end
      checks++;
      if (early) begin
        failures++;
        $display("FAIL directed_partial[%0d]: outputs changed before done, required stable", i);
      end
      checks++;
      if (sum !== es[i] || carry_out !== eco[i] || overflow !== eov[i]) begin
        failures++;
        $display("FAIL directed_result[%0d]: sum=%h co=%b ov=%b required %h %b %b",
                 i, sum, carry_out, overflow, es[i], eco[i], eov[i]);
      end
      {last_ov, last_co, last_sum} = {eov[i], eco[i], es[i]};
    end
  endtask

  task automatic test_random;
    logic [31:0] x, y;
    logic        c;
    logic [33:0] e;
    int dat, nd, nb;
    bit early;
    for (int i = 0; i < 10; i++) begin
      x = $urandom; y = $urandom; c = 1'($urandom_range(0, 1));
      if (i == 0) y = ~x;
      e = model(x, y, c);
      do_op(x, y, c, -1, dat, nd, nb, early);
      checks++;
      if ({overflow, carry_out, sum} !== e || dat !== 32 || nd !== 1 || early) begin
        failures++;
        $display("FAIL random[%0d]: a=%h b=%h c=%b got ov/co/sum=%b%b/%h done_at=%0d nd=%0d required %b%b/%h 32 1",
                 i, x, y, c, overflow, carry_out, sum, dat, nd, e[33], e[32], e[31:0]);
      end
      {last_ov, last_co, last_sum} = e;
    end
  endtask

  task automatic test_sub_inverse;
    logic [31:0] x, y, d;
    int dat, nd, nb;
    bit early;
    for (int i = 0; i < 4; i++) begin
      x = $urandom; y = $urandom;
      d = x - y;
      do_op(x, ~y, 1'b1, -1, dat, nd, nb, early);
      checks++;
      if (sum !== d || carry_out !== (x >= y)) begin
        failures++;
        $display("FAIL sub_via_add[%0d]: sum=%h co=%b required %h %b", i, sum, carry_out, d, x >= y);
      end
      {last_ov, last_co, last_sum} = model(x, ~y, 1'b1);
      do_op(d, y, 1'b0, -1, dat, nd, nb, early);
      checks++;
      if (sum !== x) begin
        failures++;
        $display("FAIL diff_plus_b[%0d]: sum=%h required %h", i, sum, x);
      end
      {last_ov, last_co, last_sum} = model(d, y, 1'b0);
    end
  endtask

  task automatic test_ignored_start;
    int inj [2] = '{10, 32};
    logic [31:0] x, y;
    logic [33:0] e;
    int dat, nd, nb;
    bit early;
    for (int i = 0; i < 2; i++) begin
      x = $urandom; y = $urandom;
      e = model(x, y, 1'b0);
      do_op(x, y, 1'b0, inj[i], dat, nd, nb, early);
      checks++;
      if (nd !== 1 || nb !== 32 || dat !== 32) begin
        failures++;
        $display("FAIL ignored_start_timing[%0d]: ndone=%0d busy=%0d done_at=%0d required 1 32 32", i, nd, nb, dat);
      end
      checks++;
      if ({overflow, carry_out, sum} !== e) begin
        failures++;
        $display("FAIL ignored_start_result[%0d]: got %b%b/%h required %b%b/%h",
                 i, overflow, carry_out, sum, e[33], e[32], e[31:0]);
      end
      {last_ov, last_co, last_sum} = e;
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] xs [3], ys [3];
    logic        cs [3];
    logic [33:0] e;
    int nd = 0;
    for (int i = 0; i < 3; i++) begin
      xs[i] = $urandom; ys[i] = $urandom; cs[i] = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    a_r = xs[0]; b_r = ys[0]; cin_r = cs[0]; start_r = 1'b1;
    for (int cyc = 0; cyc < 111; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 1 || cyc == 35) begin
        a_r = xs[cyc / 34 + 1]; b_r = ys[cyc / 34 + 1]; cin_r = cs[cyc / 34 + 1];
      end
      if (cyc == 100) start_r = 1'b0;
      if (done) begin
        if (nd < 3) begin
          e = model(xs[nd], ys[nd], cs[nd]);
          checks++;
          if (cyc !== 32 + 34 * nd || {overflow, carry_out, sum} !== e) begin
            failures++;
            $display("FAIL back_to_back[%0d]: done at %0d got %b%b/%h required at %0d %b%b/%h",
                     nd, cyc, overflow, carry_out, sum, 32 + 34 * nd, e[33], e[32], e[31:0]);
          end
          {last_ov, last_co, last_sum} = e;
        end
        nd++;
      end
    end
    checks++;
    if (nd !== 3) begin
      failures++;
      $display("FAIL back_to_back_count: ndone=%0d required 3", nd);
    end
  endtask

  task automatic test_reset_mid_op;
    int nd = 0;
    int dat, ndn, nb;
    bit early;
    logic [31:0] x, y;
    logic [33:0] e;
    @(negedge clk);
    a_r = 32'hffff_ffff; b_r = 32'hffff_ffff; cin_r = 1'b1; start_r = 1'b1;
    @(posedge clk); #1;
    start_r = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
    end
    reset_r = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({busy, done, carry_out, overflow} !== 4'b0 || sum !== 32'd0) begin
      failures++;
      $display("FAIL reset_mid_op: busy=%b done=%b sum=%h co=%b ov=%b required all 0",
               busy, done, sum, carry_out, overflow);
    end
    reset_r = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) nd++;
    end
    checks++;
    if (nd !== 0) begin
      failures++;
      $display("FAIL reset_no_done: active cycles=%0d required 0", nd);
    end
    {last_ov, last_co, last_sum} = 34'd0;
    x = $urandom; y = $urandom;
    e = model(x, y, 1'b1);
    do_op(x, y, 1'b1, -1, dat, ndn, nb, early);
    checks++;
    if ({overflow, carry_out, sum} !== e || ndn !== 1 || early) begin
      failures++;
      $display("FAIL after_reset_op: got %b%b/%h ndone=%0d required %b%b/%h 1",
               overflow, carry_out, sum, ndn, e[33], e[32], e[31:0]);
    end
    {last_ov, last_co, last_sum} = e;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_sub_inverse();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
